// File: rtl/dds_cmd_pkg.sv
// Shared constants for the DDS command parser: header bytes, FSM encoding,
// per-channel payload byte offsets and field widths.
package dds_cmd_pkg;

  localparam logic [7:0] HDR_B0 = 8'h00;
  localparam logic [7:0] HDR_B1 = 8'h00;
  localparam logic [7:0] HDR_B2 = 8'h01;
  localparam logic [7:0] HDR_B3 = 8'h01;

  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_H0     = 4'd0;
  localparam logic [STATE_W-1:0] S_H1     = 4'd1;
  localparam logic [STATE_W-1:0] S_H2     = 4'd2;
  localparam logic [STATE_W-1:0] S_H3     = 4'd3;
  localparam logic [STATE_W-1:0] S_LEN_H  = 4'd4;
  localparam logic [STATE_W-1:0] S_LEN_L  = 4'd5;
  localparam logic [STATE_W-1:0] S_PAY    = 4'd6;
  localparam logic [STATE_W-1:0] S_CHK    = 4'd7;
  localparam logic [STATE_W-1:0] S_COMMIT = 4'd8;

  localparam int FRQ_W   = 24;
  localparam int PARAM_W = 16;
  localparam int TYPE_W  = 3;

  localparam int CHAN_BYTES   = 12;
  localparam int CHAN_W       = CHAN_BYTES * 8;
  localparam int OFS_CTRL     = 0;
  localparam int OFS_FRQ      = 1;
  localparam int OFS_AMP      = 4;
  localparam int OFS_OFFSET   = 6;
  localparam int OFS_PHA      = 8;
  localparam int OFS_DUTY     = 10;
  localparam int CTRL_RUN_BIT = 3;

  typedef struct packed {
    logic               run;
    logic [TYPE_W-1:0]  typ;
    logic [FRQ_W-1:0]   frq;
    logic [PARAM_W-1:0] amp;
    logic [PARAM_W-1:0] offset;
    logic [PARAM_W-1:0] pha;
    logic [PARAM_W-1:0] duty;
  } chan_cfg_t;

  // Byte idx of a channel block; byte 0 sits in the most significant position.
  function automatic logic [7:0] chan_byte(input logic [CHAN_W-1:0] blk, input int idx);
    return blk[(CHAN_BYTES-1-idx)*8 +: 8];
  endfunction

endpackage

// File: rtl/dds_cmd_chan_unpack.sv
// Maps one big-endian 12-byte channel block onto the DDS configuration fields.
module dds_cmd_chan_unpack
  import dds_cmd_pkg::*;
(
  input  logic [CHAN_W-1:0] i_block,
  output chan_cfg_t         o_cfg
);

  logic [7:0] w_ctrl;
  logic       w_unused_ctrl;

  assign w_ctrl        = chan_byte(i_block, OFS_CTRL);
  // Upper nibble of the control byte is reserved.
  assign w_unused_ctrl = ^w_ctrl[7:4];

  assign o_cfg.run    = w_ctrl[CTRL_RUN_BIT];
  assign o_cfg.typ    = w_ctrl[TYPE_W-1:0];
  assign o_cfg.frq    = {chan_byte(i_block, OFS_FRQ), chan_byte(i_block, OFS_FRQ + 1),
                         chan_byte(i_block, OFS_FRQ + 2)};
  assign o_cfg.amp    = {chan_byte(i_block, OFS_AMP), chan_byte(i_block, OFS_AMP + 1)};
  assign o_cfg.offset = {chan_byte(i_block, OFS_OFFSET), chan_byte(i_block, OFS_OFFSET + 1)};
  assign o_cfg.pha    = {chan_byte(i_block, OFS_PHA), chan_byte(i_block, OFS_PHA + 1)};
  assign o_cfg.duty   = {chan_byte(i_block, OFS_DUTY), chan_byte(i_block, OFS_DUTY + 1)};

endmodule

// File: rtl/dds_cmd_parser.sv
// UART byte-stream frame parser committing two DDS channel configurations atomically.
// Define DDS_CMD_PARSER_CHECKSUM_EN to require a trailing modulo-256 payload sum byte.
module dds_cmd_parser
  import dds_cmd_pkg::*;
#(
  parameter int P_PAYLOAD_LEN    = 24,
  parameter int P_TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_dds1_run,
  output logic [TYPE_W-1:0]  o_dds1_type,
  output logic [FRQ_W-1:0]   o_dds1_frq,
  output logic [PARAM_W-1:0] o_dds1_amp,
  output logic [PARAM_W-1:0] o_dds1_offset,
  output logic [PARAM_W-1:0] o_dds1_pha,
  output logic [PARAM_W-1:0] o_dds1_duty,
  output logic               o_dds2_run,
  output logic [TYPE_W-1:0]  o_dds2_type,
  output logic [FRQ_W-1:0]   o_dds2_frq,
  output logic [PARAM_W-1:0] o_dds2_amp,
  output logic [PARAM_W-1:0] o_dds2_offset,
  output logic [PARAM_W-1:0] o_dds2_pha,
  output logic [PARAM_W-1:0] o_dds2_duty,
  output logic               o_cfg_valid,
  output logic               o_frame_err
);

  localparam int SHADOW_W = P_PAYLOAD_LEN * 8;
  localparam int CNT_W    = $clog2(P_PAYLOAD_LEN);
  localparam int TO_W     = $clog2(P_TIMEOUT_CYCLES + 1);

  localparam logic [15:0]      LP_LEN    = 16'(P_PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(P_PAYLOAD_LEN - 1);
  localparam logic [TO_W-1:0]  LP_TO_MAX = TO_W'(P_TIMEOUT_CYCLES);

  logic [STATE_W-1:0]  r_state;
  logic [7:0]          r_len_hi;
  logic [CNT_W-1:0]    r_pay_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [SHADOW_W-1:0] r_shadow;
  chan_cfg_t           r_cfg1;
  chan_cfg_t           r_cfg2;
  logic                r_cfg_valid;
  logic                r_frame_err;
  chan_cfg_t           w_cfg1;
  chan_cfg_t           w_cfg2;
  logic                w_timeout;
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif

  dds_cmd_chan_unpack u_unpack_ch1 (
    .i_block (r_shadow[SHADOW_W-1 -: CHAN_W]),
    .o_cfg   (w_cfg1)
  );

  dds_cmd_chan_unpack u_unpack_ch2 (
    .i_block (r_shadow[SHADOW_W-CHAN_W-1 -: CHAN_W]),
    .o_cfg   (w_cfg2)
  );

  // COMMIT is excluded so an error pulse can never coincide with o_cfg_valid.
  assign w_timeout = (r_state != S_H0) && (r_state != S_COMMIT) && (r_to_cnt == LP_TO_MAX);

  // NOTE: all state here is updated with <= so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_H0;
      r_len_hi    <= '0;
      r_pay_cnt   <= '0;
      r_to_cnt    <= '0;
      r_shadow    <= '0;
      r_cfg1      <= '0;
      r_cfg2      <= '0;
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;

      if ((r_state == S_H0) || i_rx_valid)
        r_to_cnt <= '0;
      else if (r_to_cnt != LP_TO_MAX)
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_state     <= S_H0;
      end else if (r_state == S_COMMIT) begin
        r_cfg1      <= w_cfg1;
        r_cfg2      <= w_cfg2;
        r_cfg_valid <= 1'b1;
        r_state     <= (i_rx_valid && (i_rx_data == HDR_B0)) ? S_H1 : S_H0;
      end else if (i_rx_valid) begin
        case (r_state)
          S_H0: if (i_rx_data == HDR_B0) r_state <= S_H1;
          S_H1: r_state <= (i_rx_data == HDR_B1) ? S_H2 : S_H0;
          S_H2: begin
            if (i_rx_data == HDR_B2)     r_state <= S_H3;
            else if (i_rx_data != 8'h00) r_state <= S_H0;
          end
          S_H3: begin
            if (i_rx_data == HDR_B3)      r_state <= S_LEN_H;
            else if (i_rx_data == 8'h00)  r_state <= S_H1;
            else                          r_state <= S_H0;
          end
          S_LEN_H: begin
            r_len_hi <= i_rx_data;
            r_state  <= S_LEN_L;
          end
          S_LEN_L: begin
            if ({r_len_hi, i_rx_data} == LP_LEN) begin
              r_pay_cnt <= '0;
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
              r_sum     <= '0;
`endif
              r_state   <= S_PAY;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_H0;
            end
          end
          S_PAY: begin
            // Shifting in keeps byte 0 at the top once the whole payload has arrived.
            r_shadow  <= {r_shadow[SHADOW_W-9:0], i_rx_data};
            r_pay_cnt <= r_pay_cnt + 1'b1;
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
            r_sum     <= r_sum + i_rx_data;
            if (r_pay_cnt == LP_LAST) r_state <= S_CHK;
`else
            if (r_pay_cnt == LP_LAST) r_state <= S_COMMIT;
`endif
          end
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
          S_CHK: begin
            if (i_rx_data == r_sum) begin
              r_state <= S_COMMIT;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_H0;
            end
          end
`endif
          default: r_state <= S_H0;
        endcase
      end
    end
  end

  assign o_dds1_run    = r_cfg1.run;
  assign o_dds1_type   = r_cfg1.typ;
  assign o_dds1_frq    = r_cfg1.frq;
  assign o_dds1_amp    = r_cfg1.amp;
  assign o_dds1_offset = r_cfg1.offset;
  assign o_dds1_pha    = r_cfg1.pha;
  assign o_dds1_duty   = r_cfg1.duty;
  assign o_dds2_run    = r_cfg2.run;
  assign o_dds2_type   = r_cfg2.typ;
  assign o_dds2_frq    = r_cfg2.frq;
  assign o_dds2_amp    = r_cfg2.amp;
  assign o_dds2_offset = r_cfg2.offset;
  assign o_dds2_pha    = r_cfg2.pha;
  assign o_dds2_duty   = r_cfg2.duty;
  assign o_cfg_valid   = r_cfg_valid;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Self-checking bench for dds_cmd_parser: randomized frames against a byte-map model.
module tb_dds_cmd_parser;

  localparam int PAY = 24;
  localparam int TO  = 20000;

  typedef struct packed {
    logic        run;
    logic [2:0]  typ;
    logic [23:0] frq;
    logic [15:0] amp;
    logic [15:0] offset;
    logic [15:0] pha;
    logic [15:0] duty;
  } chan_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        o_dds1_run, o_dds2_run, o_cfg_valid, o_frame_err;
  logic [2:0]  o_dds1_type, o_dds2_type;
  logic [23:0] o_dds1_frq, o_dds2_frq;
  logic [15:0] o_dds1_amp, o_dds1_offset, o_dds1_pha, o_dds1_duty;
  logic [15:0] o_dds2_amp, o_dds2_offset, o_dds2_pha, o_dds2_duty;

  chan_t act1, act2, exp1, exp2;
  logic [7:0] pay [PAY];
  int n_assert = 0, n_fail = 0;
  int cfg_pulses = 0, err_pulses = 0, both_high = 0;
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
  bit corrupt_sum = 1'b0;
`endif

  dds_cmd_parser #(.P_PAYLOAD_LEN(PAY), .P_TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_dds1_run(o_dds1_run), .o_dds1_type(o_dds1_type), .o_dds1_frq(o_dds1_frq),
    .o_dds1_amp(o_dds1_amp), .o_dds1_offset(o_dds1_offset), .o_dds1_pha(o_dds1_pha),
    .o_dds1_duty(o_dds1_duty),
    .o_dds2_run(o_dds2_run), .o_dds2_type(o_dds2_type), .o_dds2_frq(o_dds2_frq),
    .o_dds2_amp(o_dds2_amp), .o_dds2_offset(o_dds2_offset), .o_dds2_pha(o_dds2_pha),
    .o_dds2_duty(o_dds2_duty),
    .o_cfg_valid(o_cfg_valid), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  assign act1 = {o_dds1_run, o_dds1_type, o_dds1_frq, o_dds1_amp, o_dds1_offset, o_dds1_pha, o_dds1_duty};
  assign act2 = {o_dds2_run, o_dds2_type, o_dds2_frq, o_dds2_amp, o_dds2_offset, o_dds2_pha, o_dds2_duty};

  always @(posedge clk) begin
    #1;
    if (o_cfg_valid) cfg_pulses++;
    if (o_frame_err) err_pulses++;
    if (o_cfg_valid && o_frame_err) both_high++;
  end

  // Reference: fields straight from the byte map of a 12-byte channel block.
  function automatic chan_t model_chan(input int base);
    chan_t c;
    c.run    = pay[base][3];
    c.typ    = pay[base][2:0];
    c.frq    = {pay[base+1], pay[base+2], pay[base+3]};
    c.amp    = {pay[base+4], pay[base+5]};
    c.offset = {pay[base+6], pay[base+7]};
    c.pha    = {pay[base+8], pay[base+9]};
    c.duty   = {pay[base+10], pay[base+11]};
    return c;
  endfunction

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (pay[i]) s += int'(pay[i]);
    return s[7:0];
  endfunction

  task automatic model_commit();
    exp1 = model_chan(0);
    exp2 = model_chan(PAY / 2);
  endtask

  task automatic randomize_payload();
    foreach (pay[i]) pay[i] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the next negedge with the byte consumed.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx(input logic [7:0] b, input int gmax);
    if (gmax > 0) idle($urandom_range(gmax, 0));
    send_byte(b);
  endtask

  task automatic send_payload(input int from, input int upto, input int gmax);
    for (int i = from; i < upto; i++) tx(pay[i], gmax);
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
    if (upto == PAY) tx(model_sum() + (corrupt_sum ? 8'd1 : 8'd0), gmax);
`endif
  endtask

  task automatic send_frame(input logic [15:0] len, input int n_pay, input int gmax);
    tx(8'h00, gmax); tx(8'h00, gmax); tx(8'h01, gmax); tx(8'h01, gmax);
    tx(len[15:8], gmax); tx(len[7:0], gmax);
    if (len == 16'(PAY)) send_payload(0, n_pay, gmax);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_assert++;
    if (act1 !== '0 || act2 !== '0) begin
      $display("FAIL reset_outputs: ch1=%h ch2=%h required 0", act1, act2); n_fail++;
    end
    n_assert++;
    if ({o_cfg_valid, o_frame_err} !== 2'b00) begin
      $display("FAIL reset_pulses: cfg_valid/frame_err=%b required 00", {o_cfg_valid, o_frame_err}); n_fail++;
    end
    exp1 = '0; exp2 = '0;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_nominal();
    int c0 = cfg_pulses, e0 = err_pulses;
    pay = '{8'h08, 8'h4C, 8'h4B, 8'h40, 8'h05, 8'hDC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC8,
            8'h08, 8'h26, 8'h25, 8'hA0, 8'h05, 8'hDC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h20};
    send_frame(16'h0018, PAY, 0);
    n_assert++;
    if (o_cfg_valid !== 1'b0) begin
      $display("FAIL nominal_early_valid: cfg_valid=%b required 0", o_cfg_valid); n_fail++;
    end
    idle(1);
    n_assert++;
    if (o_cfg_valid !== 1'b1) begin
      $display("FAIL nominal_latency: cfg_valid=%b required 1", o_cfg_valid); n_fail++;
    end
    model_commit();
    n_assert++;
    if (o_dds1_frq !== 24'd5000000 || o_dds2_duty !== 16'd800) begin
      $display("FAIL nominal_values: frq1=%0d duty2=%0d required 5000000/800", o_dds1_frq, o_dds2_duty); n_fail++;
    end
    n_assert++;
    if ({o_dds1_run, o_dds1_type, o_dds2_run, o_dds2_type} !== 8'b1000_1000) begin
      $display("FAIL nominal_run_type: %b required 10001000",
               {o_dds1_run, o_dds1_type, o_dds2_run, o_dds2_type}); n_fail++;
    end
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2) begin
      $display("FAIL nominal_fields: ch1=%h ch2=%h required %h %h", act1, act2, exp1, exp2); n_fail++;
    end
    idle(3);
    n_assert++;
    if (cfg_pulses - c0 != 1 || err_pulses - e0 != 0) begin
      $display("FAIL nominal_pulses: cfg=%0d err=%0d required 1/0", cfg_pulses - c0, err_pulses - e0); n_fail++;
    end
  endtask

  task automatic test_bad_length();
    logic [15:0] lens [3];
    lens[0] = 16'h0016;
    lens[1] = 16'h0118;
    lens[2] = 16'(PAY + 1 + $urandom_range(200, 0));
    for (int k = 0; k < 3; k++) begin
      int c0 = cfg_pulses, e0 = err_pulses;
      randomize_payload();
      send_frame(lens[k], PAY, 2);
      n_assert++;
      if (o_frame_err !== 1'b1) begin
        $display("FAIL bad_len_err_pulse: len=%h frame_err=%b required 1", lens[k], o_frame_err); n_fail++;
      end
      idle(3);
      n_assert++;
      if (act1 !== exp1 || act2 !== exp2 || cfg_pulses != c0 || err_pulses - e0 != 1) begin
        $display("FAIL bad_len_hold: ch1=%h ch2=%h cfg=%0d err=%0d required %h %h 0 1",
                 act1, act2, cfg_pulses - c0, err_pulses - e0, exp1, exp2); n_fail++;
      end
    end
    begin
      int c0 = cfg_pulses;
      randomize_payload();
      send_frame(16'h0018, PAY, 2);
      idle(3);
      model_commit();
      n_assert++;
      if (act1 !== exp1 || act2 !== exp2 || cfg_pulses - c0 != 1) begin
        $display("FAIL bad_len_recover: ch1=%h ch2=%h cfg=%0d required %h %h 1",
                 act1, act2, cfg_pulses - c0, exp1, exp2); n_fail++;
      end
    end
  endtask

  task automatic test_overlap();
    logic [7:0] pre [2][7];
    pre[0] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
    pre[1] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    for (int k = 0; k < 2; k++) begin
      int c0 = cfg_pulses, e0 = err_pulses;
      int n_pre = (k == 0) ? 5 : 7;
      randomize_payload();
      repeat ($urandom_range(4, 0)) tx(8'($urandom_range(255, 2)), 1);
      for (int i = 0; i < n_pre; i++) tx(pre[k][i], 1);
      tx(8'h00, 1); tx(8'h18, 1);
      send_payload(0, PAY, 1);
      idle(3);
      model_commit();
      n_assert++;
      if (act1 !== exp1 || act2 !== exp2 || cfg_pulses - c0 != 1 || err_pulses != e0) begin
        $display("FAIL overlap_%0d: ch1=%h ch2=%h cfg=%0d err=%0d required %h %h 1 0",
                 k, act1, act2, cfg_pulses - c0, err_pulses - e0, exp1, exp2); n_fail++;
      end
    end
  endtask

  task automatic test_timeout();
    int c0 = cfg_pulses, e0 = err_pulses;
    randomize_payload();
    send_frame(16'h0018, 11, 1);
    idle(30000);
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2 || cfg_pulses != c0 || err_pulses - e0 != 1) begin
      $display("FAIL timeout_abort: ch1=%h ch2=%h cfg=%0d err=%0d required %h %h 0 1",
               act1, act2, cfg_pulses - c0, err_pulses - e0, exp1, exp2); n_fail++;
    end
    c0 = cfg_pulses; e0 = err_pulses;
    randomize_payload();
    send_frame(16'h0018, 11, 0);
    idle(TO - 10);
    send_payload(11, PAY, 0);
    idle(3);
    model_commit();
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2 || cfg_pulses - c0 != 1 || err_pulses != e0) begin
      $display("FAIL timeout_near_miss: ch1=%h ch2=%h cfg=%0d err=%0d required %h %h 1 0",
               act1, act2, cfg_pulses - c0, err_pulses - e0, exp1, exp2); n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    randomize_payload();
    send_frame(16'h0018, 16, 1);
    rst_n = 1'b0;
    #1;
    exp1 = '0; exp2 = '0;
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2) begin
      $display("FAIL reset_mid_frame: ch1=%h ch2=%h required 0", act1, act2); n_fail++;
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    c0 = cfg_pulses;
    randomize_payload();
    send_frame(16'h0018, PAY, 1);
    idle(3);
    model_commit();
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2 || cfg_pulses - c0 != 1) begin
      $display("FAIL reset_recover: ch1=%h ch2=%h cfg=%0d required %h %h 1",
               act1, act2, cfg_pulses - c0, exp1, exp2); n_fail++;
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int c0 = cfg_pulses;
      randomize_payload();
      send_frame(16'h0018, PAY, 3);
      idle(3);
      model_commit();
      n_assert++;
      if (act1 !== exp1 || act2 !== exp2 || cfg_pulses - c0 != 1) begin
        $display("FAIL random_frame_%0d: ch1=%h ch2=%h cfg=%0d required %h %h 1",
                 f, act1, act2, cfg_pulses - c0, exp1, exp2); n_fail++;
      end
    end
  endtask

  // Zero-gap frames: each new header's first byte lands in the COMMIT cycle.
  task automatic test_back_to_back();
    int c0 = cfg_pulses, e0 = err_pulses;
    for (int f = 0; f < 4; f++) begin
      randomize_payload();
      send_frame(16'h0018, PAY, 0);
    end
    idle(3);
    model_commit();
    n_assert++;
    if (cfg_pulses - c0 != 4 || err_pulses != e0) begin
      $display("FAIL back_to_back_count: cfg=%0d err=%0d required 4 0", cfg_pulses - c0, err_pulses - e0); n_fail++;
    end
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2) begin
      $display("FAIL back_to_back_fields: ch1=%h ch2=%h required %h %h", act1, act2, exp1, exp2); n_fail++;
    end
  endtask

`ifdef DDS_CMD_PARSER_CHECKSUM_EN
  task automatic test_checksum();
    int c0 = cfg_pulses, e0 = err_pulses;
    corrupt_sum = 1'b1;
    randomize_payload();
    send_frame(16'h0018, PAY, 1);
    corrupt_sum = 1'b0;
    idle(3);
    n_assert++;
    if (act1 !== exp1 || act2 !== exp2 || cfg_pulses != c0 || err_pulses - e0 != 1) begin
      $display("FAIL checksum_bad: ch1=%h ch2=%h cfg=%0d err=%0d required %h %h 0 1",
               act1, act2, cfg_pulses - c0, err_pulses - e0, exp1, exp2); n_fail++;
    end
  endtask
`endif

  initial begin
    idle(1);
    test_reset();
    test_nominal();
    test_bad_length();
    test_overlap();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
`ifdef DDS_CMD_PARSER_CHECKSUM_EN
    test_checksum();
`endif
    n_assert++;
    if (both_high != 0) begin
      $display("FAIL exclusive_pulses: overlap cycles=%0d required 0", both_high); n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
